// File: rtl/nn_zoom_stream.sv
// -----------------------------------------------------------------------------
// nn_zoom_stream
//
// Nearest-neighbour integer zoom on a raster pixel stream. One input row is
// captured into a single line buffer (FILL), then replayed zl times
// vertically, with each pixel repeated zl times horizontally (EMIT). The block
// then returns to FILL for the next row, or to IDLE once the last row has been
// replayed.
//
// Ports
//   clock      : single clock, rising edge
//   reset      : synchronous, active-high reset
//   start      : begins a frame when sampled high in IDLE
//   zoom       : zoom factor, sampled with start (0 -> 1, >ZOOM_MAX -> ZOOM_MAX)
//   in_pixel   : input pixel           } raster-order input stream
//   in_valid   : input pixel valid     }
//   in_ready   : block accepts input   }
//   out_pixel  : output pixel          } raster-order output stream
//   out_valid  : output pixel valid    }
//   out_ready  : sink accepts output   }
//   out_eol    : current output pixel is the last of its row
//   out_eof    : current output pixel is the last of the frame
//   busy       : high outside IDLE
//   done       : one-cycle pulse after the last output pixel is accepted
// -----------------------------------------------------------------------------
module nn_zoom_stream #(
   parameter int DATA_W   = 8,
   parameter int LARGURA  = 2,
   parameter int ALTURA   = 2,
   parameter int ZOOM_MAX = 4,
   localparam int ZW      = $clog2(ZOOM_MAX + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ZW-1:0]     zoom,
   input  logic [DATA_W-1:0] in_pixel,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_pixel,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_eol,
   output logic              out_eof,
   output logic              busy,
   output logic              done
);

   // Counters must hold the largest of width, height and zoom factor.
   localparam int MAXV = (LARGURA > ALTURA)
                         ? ((LARGURA > ZOOM_MAX) ? LARGURA : ZOOM_MAX)
                         : ((ALTURA  > ZOOM_MAX) ? ALTURA  : ZOOM_MAX);
   localparam int CW   = $clog2(MAXV + 1);
   localparam int AW   = (LARGURA > 1) ? $clog2(LARGURA) : 1;

   localparam logic [CW-1:0] LAST_COL = CW'(LARGURA - 1);
   localparam logic [CW-1:0] LAST_LIN = CW'(ALTURA - 1);
   localparam logic [CW-1:0] ZMAX_C   = CW'(ZOOM_MAX);
   localparam logic [CW-1:0] ONE_C    = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_EMIT = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;

   logic [DATA_W-1:0] r_line_buf [LARGURA];
   logic [CW-1:0]     r_linha;     // input row currently buffered
   logic [CW-1:0]     r_coluna;    // buffer column (write in FILL, read in EMIT)
   logic [CW-1:0]     r_nlinha;    // vertical replica of the buffered row
   logic [CW-1:0]     r_ncoluna;   // horizontal replica of the current pixel
   logic [CW-1:0]     r_zl;        // latched, clamped zoom factor
   logic              r_done;

   logic [CW-1:0]     w_zoom_ext;
   logic [CW-1:0]     w_zl_new;
   logic [CW-1:0]     w_zl_last;
   logic [AW-1:0]     w_buf_idx;
   logic              w_in_hs;
   logic              w_out_hs;
   logic              w_col_last;
   logic              w_ncol_last;
   logic              w_nlin_last;
   logic              w_lin_last;
   logic              w_row_end;

   assign w_zoom_ext  = CW'(zoom);
   assign w_zl_last   = r_zl - ONE_C;
   assign w_buf_idx   = r_coluna[AW-1:0];

   // Handshakes are derived from the state register directly so that the
   // next-state logic never depends on its own outputs.
   assign w_in_hs     = (r_state == S_FILL) && in_valid;
   assign w_out_hs    = (r_state == S_EMIT) && out_ready;

   assign w_col_last  = (r_coluna  == LAST_COL);
   assign w_ncol_last = (r_ncoluna == w_zl_last);
   assign w_nlin_last = (r_nlinha  == w_zl_last);
   assign w_lin_last  = (r_linha   == LAST_LIN);
   assign w_row_end   = w_out_hs && w_ncol_last && w_col_last && w_nlin_last;

   // Zoom clamp: 0 behaves as 1, anything above ZOOM_MAX saturates.
   always_comb begin
      w_zl_new = w_zoom_ext;
      if (w_zoom_ext == '0) begin
         w_zl_new = ONE_C;
      end else if (w_zoom_ext > ZMAX_C) begin
         w_zl_new = ZMAX_C;
      end
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state and handshake outputs.
   // NOTE: every signal written here gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b1;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_state_next = S_FILL;
            end
         end
         S_FILL: begin
            in_ready = 1'b1;
            if (w_in_hs && w_col_last) begin
               w_state_next = S_EMIT;
            end
         end
         S_EMIT: begin
            out_valid = 1'b1;
            if (w_row_end) begin
               w_state_next = w_lin_last ? S_IDLE : S_FILL;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Counters, zoom latch and done pulse.
   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_linha   <= '0;
         r_coluna  <= '0;
         r_nlinha  <= '0;
         r_ncoluna <= '0;
         r_zl      <= ONE_C;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_zl      <= w_zl_new;
                  r_linha   <= '0;
                  r_coluna  <= '0;
                  r_nlinha  <= '0;
                  r_ncoluna <= '0;
               end
            end
            S_FILL: begin
               if (w_in_hs) begin
                  if (w_col_last) begin
                     r_coluna  <= '0;
                     r_ncoluna <= '0;
                     r_nlinha  <= '0;
                  end else begin
                     r_coluna <= r_coluna + ONE_C;
                  end
               end
            end
            S_EMIT: begin
               if (w_out_hs) begin
                  // Innermost: horizontal replica, then column, then
                  // vertical replica; wrapping the last ends the row.
                  if (!w_ncol_last) begin
                     r_ncoluna <= r_ncoluna + ONE_C;
                  end else begin
                     r_ncoluna <= '0;
                     if (!w_col_last) begin
                        r_coluna <= r_coluna + ONE_C;
                     end else begin
                        r_coluna <= '0;
                        if (!w_nlin_last) begin
                           r_nlinha <= r_nlinha + ONE_C;
                        end else begin
                           r_nlinha <= '0;
                           if (w_lin_last) begin
                              r_done <= 1'b1;
                           end else begin
                              r_linha <= r_linha + ONE_C;
                           end
                        end
                     end
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Line buffer.
   // NOTE: the buffer is deliberately not reset; every entry is rewritten in
   // FILL before EMIT can read it, so a reset would only cost logic.
   always_ff @(posedge clock) begin
      if (!reset && w_in_hs) begin
         r_line_buf[w_buf_idx] <= in_pixel;
      end
   end

   assign out_pixel = out_valid ? r_line_buf[w_buf_idx] : '0;
   assign out_eol   = out_valid && w_col_last && w_ncol_last;
   assign out_eof   = out_eol && w_nlin_last && w_lin_last;
   assign done      = r_done;

endmodule

// File: tb/tb_nn_zoom_stream.sv
// -----------------------------------------------------------------------------
// tb_nn_zoom_stream
//
// Self-checking bench for nn_zoom_stream (2x2 frame, ZOOM_MAX=4). A frame-level
// model expands the input frame into the expected output sequence
// (output(r,c) = input(r/zl, c/zl)); a negedge compare process checks every
// valid output cycle against it, and literal sequences pin the model.
// -----------------------------------------------------------------------------
module tb_nn_zoom_stream;

   localparam int DATA_W   = 8;
   localparam int LARGURA  = 2;
   localparam int ALTURA   = 2;
   localparam int ZOOM_MAX = 4;
   localparam int ZW       = $clog2(ZOOM_MAX + 1);
   localparam int NPIX     = LARGURA * ALTURA;

   typedef struct {
      logic [DATA_W-1:0] pix;
      logic              eol;
      logic              eof;
   } exp_t;

   logic              clock = 1'b0;
   logic              reset;
   logic              start;
   logic [ZW-1:0]     zoom;
   logic [DATA_W-1:0] in_pixel;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] out_pixel;
   logic              out_valid;
   logic              out_ready;
   logic              out_eol;
   logic              out_eof;
   logic              busy;
   logic              done;

   int   checks   = 0;
   int   failures = 0;
   int   cyc_cnt  = 0;
   int   eof_cyc  = -100;
   int   exp_n    = 0;
   bit   chk_en   = 1'b0;
   bit   rand_rdy = 1'b0;

   int   frame_pix [NPIX];
   exp_t exp_q [$];
   logic [DATA_W-1:0] cap_pix [$];
   logic              cap_eol [$];
   logic              cap_eof [$];

   nn_zoom_stream #(
      .DATA_W  (DATA_W),
      .LARGURA (LARGURA),
      .ALTURA  (ALTURA),
      .ZOOM_MAX(ZOOM_MAX)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .zoom     (zoom),
      .in_pixel (in_pixel),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_pixel(out_pixel),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_eol  (out_eol),
      .out_eof  (out_eof),
      .busy     (busy),
      .done     (done)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc_cnt);
      end
   endtask

   // Sink readiness: always ready, or a coin flip per cycle.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output compare against the model queue.
   always @(negedge clock) begin
      if (chk_en) begin
         check("ready_valid_exclusive", 32'(in_ready && out_valid), 0);
         if (done) check("done_before_all_out", exp_q.size(), 0);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("extra_output", 32'(out_valid), 0);
            end else begin
               check("out_pixel", 32'(out_pixel), 32'(exp_q[0].pix));
               check("out_eol",   32'(out_eol),   32'(exp_q[0].eol));
               check("out_eof",   32'(out_eof),   32'(exp_q[0].eof));
               if (out_ready) begin
                  cap_pix.push_back(out_pixel);
                  cap_eol.push_back(out_eol);
                  cap_eof.push_back(out_eof);
                  if (out_eof) eof_cyc = cyc_cnt;
                  exp_q.delete(0);
               end
            end
         end
      end
   end

   // Frame model: expand the input frame by zl in both directions.
   task automatic model_frame(input int z);
      int   zl;
      exp_t e;
      zl = (z == 0) ? 1 : ((z > ZOOM_MAX) ? ZOOM_MAX : z);
      exp_q.delete();
      cap_pix.delete();
      cap_eol.delete();
      cap_eof.delete();
      for (int r = 0; r < ALTURA * zl; r++) begin
         for (int c = 0; c < LARGURA * zl; c++) begin
            e.pix = DATA_W'(frame_pix[(r / zl) * LARGURA + (c / zl)]);
            e.eol = (c == LARGURA * zl - 1);
            e.eof = e.eol && (r == ALTURA * zl - 1);
            exp_q.push_back(e);
         end
      end
      exp_n = exp_q.size();
   endtask

   task automatic do_start(input int z);
      @(posedge clock);
      #1;
      zoom  = ZW'(z);
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   // Feed n pixels of frame_pix; optional random gaps; optionally pulse start
   // (zoom 3) once the first row has been taken in and EMIT is running.
   task automatic feed(input int n, input bit gaps, input bit pulse_start);
      int idx    = 0;
      int cyc    = 0;
      bit hs;
      bit pulsed = 1'b0;
      in_valid = 1'b1;
      in_pixel = DATA_W'(frame_pix[0]);
      while (idx < n && cyc < 5000) begin
         @(negedge clock);
         hs = in_valid && in_ready;
         @(posedge clock);
         #1;
         cyc++;
         start = 1'b0;
         if (hs) idx++;
         if (pulse_start && !pulsed && idx == LARGURA) begin
            start  = 1'b1;
            zoom   = ZW'(3);
            pulsed = 1'b1;
         end
         if (idx < n) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_pixel = DATA_W'(frame_pix[idx]);
         end
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (idx < n) check("feed_timeout", idx, n);
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clock);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check("done_seen", 32'(seen), 1);
      check("done_one_cycle_after_eof", cyc_cnt - eof_cyc, 1);
      check("model_left", exp_q.size(), 0);
      check("out_count", cap_pix.size(), exp_n);
      @(negedge clock);
      check("done_pulse_width", 32'(done), 0);
      check("busy_after_frame", 32'(busy), 0);
   endtask

   // Hand-computed zoom=2 result for frame 2,4,7,9.
   task automatic check_lit_zoom2();
      int lit [16] = '{2, 2, 4, 4, 2, 2, 4, 4, 7, 7, 9, 9, 7, 7, 9, 9};
      check("lit2_count", cap_pix.size(), 16);
      for (int i = 0; i < 16 && i < cap_pix.size(); i++) begin
         check("lit2_pixel", 32'(cap_pix[i]), lit[i]);
         check("lit2_eol",   32'(cap_eol[i]), 32'(i % 4 == 3));
         check("lit2_eof",   32'(cap_eof[i]), 32'(i == 15));
      end
   endtask

   // Hand-computed zoom=1 result for frame 2,4,7,9.
   task automatic check_lit_zoom1();
      int lit [4] = '{2, 4, 7, 9};
      check("lit1_count", cap_pix.size(), 4);
      for (int i = 0; i < 4 && i < cap_pix.size(); i++) begin
         check("lit1_pixel", 32'(cap_pix[i]), lit[i]);
         check("lit1_eol",   32'(cap_eol[i]), 32'(i % 2 == 1));
         check("lit1_eof",   32'(cap_eof[i]), 32'(i == 3));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got5;
      reset    = 1'b1;
      start    = 1'b0;
      zoom     = '0;
      in_pixel = '0;
      in_valid = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check("rst_busy",      32'(busy),      0);
      check("rst_in_ready",  32'(in_ready),  0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_done",      32'(done),      0);
      check("rst_out_pixel", 32'(out_pixel), 0);
      check("rst_out_eol",   32'(out_eol),   0);
      check("rst_out_eof",   32'(out_eof),   0);

      frame_pix = '{2, 4, 7, 9};
      chk_en    = 1'b1;

      // zoom = 2, sink always ready
      model_frame(2);
      do_start(2);
      check("busy_in_fill", 32'(busy), 1);
      feed(NPIX, 1'b0, 1'b0);
      wait_done();
      check_lit_zoom2();

      // zoom = 1: pass-through
      model_frame(1);
      do_start(1);
      feed(NPIX, 1'b0, 1'b0);
      wait_done();
      check_lit_zoom1();

      // zoom = 0 behaves as zoom = 1
      model_frame(0);
      do_start(0);
      feed(NPIX, 1'b0, 1'b0);
      wait_done();
      check_lit_zoom1();

      // zoom = 7 saturates at ZOOM_MAX = 4 -> 8x8 output
      frame_pix = '{10, 20, 30, 40};
      model_frame(7);
      do_start(7);
      feed(NPIX, 1'b0, 1'b0);
      wait_done();
      check("z7_count", cap_pix.size(), 64);
      check("z7_pix0",  32'(cap_pix[0]),  10);
      check("z7_pix4",  32'(cap_pix[4]),  20);
      check("z7_pix8",  32'(cap_pix[8]),  10);
      check("z7_pix32", 32'(cap_pix[32]), 30);
      check("z7_pix63", 32'(cap_pix[63]), 40);

      // zoom = 2 with random sink stalls and input gaps
      frame_pix = '{2, 4, 7, 9};
      rand_rdy  = 1'b1;
      model_frame(2);
      do_start(2);
      feed(NPIX, 1'b1, 1'b0);
      wait_done();
      check_lit_zoom2();
      rand_rdy = 1'b0;

      // reset after the 5th output of a zoom = 2 frame
      model_frame(2);
      do_start(2);
      feed(LARGURA, 1'b0, 1'b0);
      got5 = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clock);
         if (cap_pix.size() >= 5) begin
            got5 = 1'b1;
            break;
         end
      end
      check("reached_5th_output", 32'(got5), 1);
      @(posedge clock);
      #1;
      chk_en = 1'b0;
      reset  = 1'b1;
      @(posedge clock);
      #1;
      check("mid_rst_busy",      32'(busy),      0);
      check("mid_rst_out_valid", 32'(out_valid), 0);
      check("mid_rst_in_ready",  32'(in_ready),  0);
      reset = 1'b0;
      exp_q.delete();
      model_frame(2);
      chk_en = 1'b1;
      do_start(2);
      feed(NPIX, 1'b0, 1'b0);
      wait_done();
      check_lit_zoom2();

      // start with zoom = 3 pulsed during EMIT is ignored
      model_frame(2);
      do_start(2);
      feed(NPIX, 1'b0, 1'b1);
      wait_done();
      check_lit_zoom2();
      repeat (3) @(negedge clock);
      check("no_restart_busy", 32'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
